// File: rtl/rob_pkg.sv
// Shared types and helpers for the multi-port reorder buffer.
// Entry layout and age arithmetic live here so top and bench agree on them.
package rob_pkg;

  localparam int ROB_WIDTH    = 4;
  localparam int ROB_SIZE     = 1 << ROB_WIDTH;
  localparam int PREG_WIDTH   = 7;
  localparam int NUM_CDB      = 2;
  localparam int COMMIT_WIDTH = 2;

  typedef struct packed {
    logic                  valid;
    logic                  busy;
    logic                  is_branch;
    logic                  reg_write;
    logic [PREG_WIDTH-1:0] old_prd;
    logic [31:0]           pc;
  } rob_entry_t;

  // Distance from the head; wraps naturally in ROB_WIDTH-bit arithmetic.
  function automatic logic [ROB_WIDTH-1:0] rob_age(input logic [ROB_WIDTH-1:0] tag,
                                                   input logic [ROB_WIDTH-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/rob_multi_if.sv
// Dispatch, writeback, commit and recovery signals of the reorder buffer.
// The master side is dispatch/execute; the slave side is the ROB itself.
interface rob_multi_if #(
  parameter int ROB_WIDTH    = 4,
  parameter int PREG_WIDTH   = 7,
  parameter int NUM_CDB      = 2,
  parameter int COMMIT_WIDTH = 2
);

  logic                             i_alloc_valid;
  logic [PREG_WIDTH-1:0]            i_old_prd;
  logic                             i_is_branch;
  logic                             i_reg_write;
  logic [31:0]                      i_pc;
  logic                             o_alloc_ready;
  logic [ROB_WIDTH-1:0]             o_alloc_tag;
  logic [NUM_CDB-1:0]               i_cdb_valid;
  logic [NUM_CDB*ROB_WIDTH-1:0]     i_cdb_tag;
  logic [COMMIT_WIDTH-1:0]          o_commit_valid;
  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] o_commit_tag;
  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] o_commit_old_preg;
  logic [COMMIT_WIDTH-1:0]          o_commit_reg_write;
  logic [COMMIT_WIDTH*32-1:0]       o_commit_pc;
  logic                             i_flush_valid;
  logic [ROB_WIDTH-1:0]             i_flush_tag;
  logic [ROB_WIDTH:0]               o_count;
  logic                             o_empty;

  modport master (
    output i_alloc_valid, i_old_prd, i_is_branch, i_reg_write, i_pc,
    output i_cdb_valid, i_cdb_tag, i_flush_valid, i_flush_tag,
    input  o_alloc_ready, o_alloc_tag, o_commit_valid, o_commit_tag,
    input  o_commit_old_preg, o_commit_reg_write, o_commit_pc, o_count, o_empty
  );

  modport slave (
    input  i_alloc_valid, i_old_prd, i_is_branch, i_reg_write, i_pc,
    input  i_cdb_valid, i_cdb_tag, i_flush_valid, i_flush_tag,
    output o_alloc_ready, o_alloc_tag, o_commit_valid, o_commit_tag,
    output o_commit_old_preg, o_commit_reg_write, o_commit_pc, o_count, o_empty
  );

endinterface

// File: rtl/rob_commit_select.sv
// Picks the in-order retire lanes: a contiguous prefix of ready entries
// starting at the head, bounded by the occupancy count.
module rob_commit_select #(
  parameter int ROB_WIDTH    = 4,
  parameter int COMMIT_WIDTH = 2,
  parameter int NCW          = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [(1<<ROB_WIDTH)-1:0] ready,
  input  logic [ROB_WIDTH-1:0]      head,
  input  logic [ROB_WIDTH:0]        count,
  output logic [COMMIT_WIDTH-1:0]   commit_valid,
  output logic [NCW-1:0]            ncommit
);

  logic                 chain;
  logic [ROB_WIDTH-1:0] idx;

  // A lane may only retire if every older lane retires too.
  always_comb begin
    commit_valid = '0;
    ncommit      = '0;
    chain        = 1'b1;
    idx          = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      idx             = head + ROB_WIDTH'(k);
      chain           = chain && ((ROB_WIDTH+1)'(k) < count) && ready[idx];
      commit_valid[k] = chain;
      ncommit         = ncommit + NCW'(chain);
    end
  end

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer with tail-owned allocation, multi-port completion,
// multi-lane in-order commit and selective squash of younger entries.
module rob_multi
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH    = rob_pkg::ROB_WIDTH,
  parameter int PREG_WIDTH   = rob_pkg::PREG_WIDTH,
  parameter int NUM_CDB      = rob_pkg::NUM_CDB,
  parameter int COMMIT_WIDTH = rob_pkg::COMMIT_WIDTH
) (
  input logic        clk,
  input logic        reset,
  rob_multi_if.slave bus
);

  localparam int SIZE = 1 << ROB_WIDTH;
  localparam int NCW  = $clog2(COMMIT_WIDTH + 1);

  rob_entry_t           entries [SIZE];
  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH:0]   count;

  logic                 full;
  logic                 alloc_fire;
  logic [ROB_WIDTH-1:0] flush_age;
  logic [SIZE-1:0]      squash;
  logic [SIZE-1:0]      ready;
  logic [SIZE-1:0]      committed;
  logic [SIZE-1:0]      cdb_hit;
  logic [NCW-1:0]       ncommit;

  assign full       = (count == (ROB_WIDTH+1)'(SIZE));
  assign alloc_fire = bus.i_alloc_valid && !full && !bus.i_flush_valid;
  assign flush_age  = rob_age(bus.i_flush_tag, head);

  // Squashed entries are excluded from ready so a flush can never retire
  // anything younger than the mispredicted branch.
  always_comb begin
    squash    = '0;
    ready     = '0;
    committed = '0;
    cdb_hit   = '0;
    for (int i = 0; i < SIZE; i++) begin
      squash[i] = bus.i_flush_valid && entries[i].valid &&
                  (rob_age(ROB_WIDTH'(i), head) > flush_age);
      ready[i]  = entries[i].valid && !entries[i].busy && !squash[i];
    end
    for (int k = 0; k < COMMIT_WIDTH; k++)
      if (bus.o_commit_valid[k]) committed[head + ROB_WIDTH'(k)] = 1'b1;
    for (int p = 0; p < NUM_CDB; p++)
      if (bus.i_cdb_valid[p]) cdb_hit[bus.i_cdb_tag[p*ROB_WIDTH +: ROB_WIDTH]] = 1'b1;
  end

  rob_commit_select #(
    .ROB_WIDTH   (ROB_WIDTH),
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .NCW         (NCW)
  ) u_select (
    .ready       (ready),
    .head        (head),
    .count       (count),
    .commit_valid(bus.o_commit_valid),
    .ncommit     (ncommit)
  );

  // Allocation owns the tail slot outright; a stray CDB write to it is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].busy  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (alloc_fire && (tail == ROB_WIDTH'(i))) begin
          entries[i] <= '{valid: 1'b1, busy: 1'b1, is_branch: bus.i_is_branch,
                          reg_write: bus.i_reg_write, old_prd: bus.i_old_prd,
                          pc: bus.i_pc};
        end else if (squash[i] || committed[i]) begin
          entries[i].valid <= 1'b0;
          entries[i].busy  <= 1'b0;
        end else if (cdb_hit[i] && entries[i].valid) begin
          entries[i].busy <= 1'b0;
        end
      end
    end
  end

  // On a flush the branch becomes the youngest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head + ROB_WIDTH'(ncommit);
      if (bus.i_flush_valid) begin
        tail  <= bus.i_flush_tag + ROB_WIDTH'(1);
        count <= (ROB_WIDTH+1)'(flush_age) + (ROB_WIDTH+1)'(1) - (ROB_WIDTH+1)'(ncommit);
      end else begin
        if (alloc_fire) tail <= tail + ROB_WIDTH'(1);
        count <= count + (ROB_WIDTH+1)'(alloc_fire) - (ROB_WIDTH+1)'(ncommit);
      end
    end
  end

  assign bus.o_alloc_ready = !full;
  assign bus.o_alloc_tag   = tail;
  assign bus.o_count       = count;
  assign bus.o_empty       = (count == '0);

  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_lane
    logic [ROB_WIDTH-1:0] lane_idx;
    assign lane_idx = head + ROB_WIDTH'(k);
    assign bus.o_commit_tag[k*ROB_WIDTH +: ROB_WIDTH] = lane_idx;
    assign bus.o_commit_reg_write[k] = entries[lane_idx].reg_write;
    assign bus.o_commit_old_preg[k*PREG_WIDTH +: PREG_WIDTH] =
      entries[lane_idx].reg_write ? entries[lane_idx].old_prd : '0;
    assign bus.o_commit_pc[k*32 +: 32] = entries[lane_idx].pc;
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: a queue model of in-flight instructions is
// compared every cycle, and hand-computed values pin key scenarios.
module tb_rob_multi;

  localparam int RW = 4;
  localparam int PW = 7;
  localparam int NC = 2;
  localparam int CW = 2;
  localparam int SZ = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rob_multi_if #(.ROB_WIDTH(RW), .PREG_WIDTH(PW), .NUM_CDB(NC), .COMMIT_WIDTH(CW)) rif ();

  rob_multi #(.ROB_WIDTH(RW), .PREG_WIDTH(PW), .NUM_CDB(NC), .COMMIT_WIDTH(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (rif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order view of in-flight instructions, oldest first.
  typedef struct {
    logic [RW-1:0] tag;
    bit            done;
    bit            reg_write;
    logic [PW-1:0] old_prd;
    logic [31:0]   pc;
  } m_entry_t;

  m_entry_t      mq[$];
  logic [RW-1:0] m_tail;
  bit            model_live = 0;

  function automatic int find_tag(input logic [RW-1:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  function automatic int model_commits();
    int lim = mq.size();
    int n = 0;
    if (rif.i_flush_valid) begin
      int f = find_tag(rif.i_flush_tag);
      if (f >= 0) lim = f + 1;
    end
    for (int k = 0; k < CW; k++) begin
      if (k < lim && mq[k].done) n++;
      else break;
    end
    return n;
  endfunction

  always @(posedge clk) begin : model_update
    int n, f;
    bit acc;
    m_entry_t e;
    if (reset) begin
      mq.delete();
      m_tail = '0;
      model_live = 1;
    end else if (model_live) begin
      n = model_commits();
      f = -1;
      if (rif.i_flush_valid) begin
        f = find_tag(rif.i_flush_tag);
        check_output("flush_tag_in_flight", 64'(f >= 0), 64'd1);
      end
      for (int p = 0; p < NC; p++)
        if (rif.i_cdb_valid[p])
          foreach (mq[i]) if (mq[i].tag == rif.i_cdb_tag[p*RW +: RW]) mq[i].done = 1;
      acc = rif.i_alloc_valid && (mq.size() < SZ) && !rif.i_flush_valid;
      if (rif.i_flush_valid && f >= 0) begin
        while (mq.size() > f + 1) void'(mq.pop_back());
        m_tail = rif.i_flush_tag + RW'(1);
      end
      repeat (n) void'(mq.pop_front());
      if (acc) begin
        e.tag = m_tail; e.done = 0; e.reg_write = rif.i_reg_write;
        e.old_prd = rif.i_old_prd; e.pc = rif.i_pc;
        mq.push_back(e);
        m_tail = m_tail + RW'(1);
      end
    end
  end

  always @(negedge clk) begin : compare
    int n;
    if (model_live) begin
      n = model_commits();
      check_output("alloc_ready", rif.o_alloc_ready, 64'(mq.size() < SZ));
      check_output("alloc_tag", rif.o_alloc_tag, m_tail);
      check_output("count", rif.o_count, mq.size());
      check_output("empty", rif.o_empty, 64'(mq.size() == 0));
      check_output("commit_valid", rif.o_commit_valid, (64'd1 << n) - 1);
      for (int k = 0; k < n; k++) begin
        check_output("commit_tag", rif.o_commit_tag[k*RW +: RW], mq[k].tag);
        check_output("commit_reg_write", rif.o_commit_reg_write[k], mq[k].reg_write);
        check_output("commit_old_preg", rif.o_commit_old_preg[k*PW +: PW],
                     mq[k].reg_write ? mq[k].old_prd : '0);
        check_output("commit_pc", rif.o_commit_pc[k*32 +: 32], mq[k].pc);
      end
    end
  end

  task automatic clear_inputs();
    rif.i_alloc_valid = 0; rif.i_old_prd = '0; rif.i_is_branch = 0;
    rif.i_reg_write = 0; rif.i_pc = '0; rif.i_cdb_valid = '0;
    rif.i_cdb_tag = '0; rif.i_flush_valid = 0; rif.i_flush_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    clear_inputs();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic apply_stimulus(input logic [PW-1:0] old, input bit rw, input bit br,
                                input logic [31:0] pc);
    rif.i_alloc_valid = 1; rif.i_old_prd = old; rif.i_reg_write = rw;
    rif.i_is_branch = br; rif.i_pc = pc;
    tick();
  endtask

  task automatic complete2(input bit v0, input logic [RW-1:0] t0,
                           input bit v1, input logic [RW-1:0] t1);
    rif.i_cdb_valid = {v1, v0};
    rif.i_cdb_tag = {t1, t0};
    tick();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    check_output("rst_alloc_ready", rif.o_alloc_ready, 1);
    check_output("rst_alloc_tag", rif.o_alloc_tag, 0);
    check_output("rst_count", rif.o_count, 0);
    check_output("rst_empty", rif.o_empty, 1);
    check_output("rst_commit_valid", rif.o_commit_valid, 0);

    // Fill to capacity, then try one more.
    for (int i = 0; i < SZ; i++) begin
      check_output("fill_tag", rif.o_alloc_tag, i);
      apply_stimulus(7'(i), 1, 0, 32'h1000 + 32'(4*i));
    end
    check_output("full_count", rif.o_count, 16);
    check_output("full_ready", rif.o_alloc_ready, 0);
    apply_stimulus(7'h11, 1, 0, 32'h2000);
    check_output("full_tail", rif.o_alloc_tag, 0);
    check_output("full_count_hold", rif.o_count, 16);

    // Two completions on swapped ports retire together; tag 2 waits.
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(7'(10 + i), 1, 0, 32'h100 + 32'(4*i));
    complete2(1, 4'd1, 1, 4'd0);
    check_output("dual_commit_valid", rif.o_commit_valid, 2'b11);
    check_output("dual_commit_tag", rif.o_commit_tag, 8'h10);
    check_output("dual_count_pre", rif.o_count, 3);
    tick();
    check_output("dual_count_post", rif.o_count, 1);
    check_output("dual_hold", rif.o_commit_valid, 0);
    complete2(1, 4'd2, 0, 4'd0);
    check_output("late_commit", rif.o_commit_valid, 2'b01);
    check_output("late_tag", rif.o_commit_tag[3:0], 2);
    tick();
    check_output("late_empty", rif.o_empty, 1);

    // Flush at the branch (tag 2) while 0 and 1 retire.
    do_reset();
    for (int i = 0; i < 6; i++) apply_stimulus(7'(20 + i), 1, i == 2, 32'h300 + 32'(4*i));
    complete2(1, 4'd2, 1, 4'd3);
    complete2(1, 4'd4, 1, 4'd5);
    complete2(1, 4'd0, 1, 4'd1);
    rif.i_flush_valid = 1; rif.i_flush_tag = 4'd2;
    #1;
    check_output("flush_commit_valid", rif.o_commit_valid, 2'b11);
    check_output("flush_commit_tag", rif.o_commit_tag, 8'h10);
    tick();
    check_output("flush_count", rif.o_count, 1);
    check_output("flush_tail", rif.o_alloc_tag, 3);
    check_output("flush_branch_commit", rif.o_commit_valid, 2'b01);
    tick();
    check_output("flush_drained", rif.o_empty, 1);

    // Move head to 14, refill, and retire across the wrap.
    do_reset();
    for (int i = 0; i < 14; i++) apply_stimulus(7'(i), 1, 0, 32'h400 + 32'(4*i));
    for (int i = 0; i < 7; i++) complete2(1, 4'(2*i), 1, 4'(2*i + 1));
    tick();
    tick();
    check_output("wrap_count0", rif.o_count, 0);
    check_output("wrap_tail14", rif.o_alloc_tag, 14);
    for (int i = 0; i < SZ; i++) begin
      check_output("wrap_fill_tag", rif.o_alloc_tag, (14 + i) % 16);
      apply_stimulus(7'(40 + i), 1, 0, 32'h500 + 32'(4*i));
    end
    check_output("wrap_full_ready", rif.o_alloc_ready, 0);
    complete2(1, 4'd14, 1, 4'd15);
    rif.i_alloc_valid = 1; rif.i_old_prd = 7'h33; rif.i_reg_write = 1; rif.i_pc = 32'h600;
    #1;
    check_output("wrap_refused", rif.o_alloc_ready, 0);
    check_output("wrap_commit_valid", rif.o_commit_valid, 2'b11);
    check_output("wrap_commit_tag", rif.o_commit_tag, 8'hfe);
    tick();
    check_output("wrap_count14", rif.o_count, 14);
    check_output("wrap_next_tag", rif.o_alloc_tag, 14);
    apply_stimulus(7'h34, 1, 0, 32'h604);
    check_output("wrap_after_alloc", rif.o_alloc_tag, 15);
    check_output("wrap_count15", rif.o_count, 15);

    // A non-writing entry reports no register to free.
    do_reset();
    apply_stimulus(7'h55, 0, 0, 32'h700);
    apply_stimulus(7'h2a, 1, 0, 32'h704);
    complete2(1, 4'd0, 1, 4'd1);
    check_output("nrw_commit_valid", rif.o_commit_valid, 2'b11);
    check_output("nrw_old_preg", rif.o_commit_old_preg, 14'h1500);
    check_output("nrw_reg_write", rif.o_commit_reg_write, 2'b10);
    check_output("nrw_pc", rif.o_commit_pc, 64'h0000_0704_0000_0700);
    tick();

    // Duplicate tags on both ports complete the entry once.
    do_reset();
    apply_stimulus(7'h01, 1, 0, 32'h800);
    apply_stimulus(7'h02, 1, 0, 32'h804);
    complete2(1, 4'd0, 1, 4'd0);
    check_output("dup_commit_valid", rif.o_commit_valid, 2'b01);
    tick();
    check_output("dup_count", rif.o_count, 1);

    // Reset wins over a concurrent flush.
    do_reset();
    for (int i = 0; i < 7; i++) apply_stimulus(7'(60 + i), 1, 0, 32'h900 + 32'(4*i));
    check_output("mid_count7", rif.o_count, 7);
    rif.i_flush_valid = 1; rif.i_flush_tag = 4'd3;
    reset = 1;
    tick();
    reset = 0;
    check_output("mid_count", rif.o_count, 0);
    check_output("mid_empty", rif.o_empty, 1);
    check_output("mid_commit_valid", rif.o_commit_valid, 0);
    check_output("mid_alloc_tag", rif.o_alloc_tag, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
